// File: rtl/mul_pkg.sv
// mul_pkg: shared multiplier widths and row types
package mul_pkg;
  localparam int DATA_LEN = 8;
  localparam int PROD_W = 2 * DATA_LEN;
  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [DATA_LEN-1:0] half_t;
endpackage

// File: rtl/mul_cpa_seg.sv
// mul_cpa_seg: one half-width carry-propagate segment with carry in and out
module mul_cpa_seg #(
  parameter int W = mul_pkg::DATA_LEN
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/mul_cpa_pipe.sv
// mul_cpa_pipe: two-stage pipelined final adder for the reduction-tree rows
module mul_cpa_pipe #(
  parameter int DATA_LEN = mul_pkg::DATA_LEN,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_LEN-1:0]   in_row_a,
  input  logic [2*DATA_LEN-1:0]   in_row_b,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_LEN-1:0]   out_product,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_carry,
  output logic                    err_sticky
);
  logic                s1_valid, s1_c_lo, c_lo, c_hi;
  logic [DATA_LEN-1:0] s1_lo, s1_a_hi, s1_b_hi, lo, hi;
  logic [TAG_W-1:0]    s1_tag;
  logic                s1_load, s2_load;
  assign s2_load = !out_valid || out_ready;
  assign s1_load = !s1_valid || s2_load;
  assign in_ready = s1_load;
  mul_cpa_seg #(.W(DATA_LEN)) u_lo (
    .a(in_row_a[DATA_LEN-1:0]), .b(in_row_b[DATA_LEN-1:0]), .cin(1'b0), .sum(lo), .cout(c_lo)
  );
  mul_cpa_seg #(.W(DATA_LEN)) u_hi (
    .a(s1_a_hi), .b(s1_b_hi), .cin(s1_c_lo), .sum(hi), .cout(c_hi)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_lo       <= '0;
      s1_c_lo     <= 1'b0;
      s1_a_hi     <= '0;
      s1_b_hi     <= '0;
      s1_tag      <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
      out_carry   <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_lo   <= lo;
          s1_c_lo <= c_lo;
          s1_a_hi <= in_row_a[2*DATA_LEN-1:DATA_LEN];
          s1_b_hi <= in_row_b[2*DATA_LEN-1:DATA_LEN];
          s1_tag  <= in_tag;
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_product <= {hi, s1_lo};
          out_tag     <= s1_tag;
          out_carry   <= c_hi;
        end
      end
      // a carry out of the top bit means the upstream tree produced bad rows
      if (out_valid && out_ready && out_carry) err_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mul_cpa_pipe.sv
// tb_mul_cpa_pipe: directed and randomized checks of mul_cpa_pipe against a queue model
module tb_mul_cpa_pipe;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [15:0] in_row_a = '0, in_row_b = '0, out_product;
  logic [3:0]  in_tag = '0, out_tag;
  logic        out_carry, err_sticky;
  int          errors = 0, checks = 0;

  typedef struct { logic [16:0] s; logic [3:0] t; int acc; } item_t;

  mul_cpa_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_row_a(in_row_a), .in_row_b(in_row_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .out_tag(out_tag), .out_carry(out_carry), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({out_valid, out_product, out_tag, out_carry, err_sticky} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b p=%h t=%h c=%b e=%b want all zero",
               out_valid, out_product, out_tag, out_carry, err_sticky);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // single transactions: cross-segment carry, maximum product, overflow
  task automatic test_single_products;
    logic [15:0] ta[3] = '{16'h00F0, 16'hFE00, 16'h8000};
    logic [15:0] tb[3] = '{16'h0010, 16'h0001, 16'h8000};
    logic [15:0] tp[3] = '{16'h0100, 16'hFE01, 16'h0000};
    logic [3:0]  tt[3] = '{4'd3, 4'd4, 4'd5};
    logic        tc[3] = '{1'b0, 1'b0, 1'b1};
    logic        te[3] = '{1'b0, 1'b0, 1'b1};
    for (int n = 0; n < 3; n++) begin
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        in_valid = (k == 0);
        in_row_a = ta[n]; in_row_b = tb[n]; in_tag = tt[n];
        #1;
        checks++;
        if (out_valid !== (k == 2)) begin
          errors++; $display("FAIL single%0d_valid_k%0d: got %b want %b", n, k, out_valid, k == 2);
        end
        if (k == 0) begin
          checks++;
          if (in_ready !== 1'b1) begin errors++; $display("FAIL single%0d_in_ready: got %b want 1", n, in_ready); end
        end
        if (k == 2) begin
          checks++;
          if ({out_product, out_tag, out_carry} !== {tp[n], tt[n], tc[n]}) begin
            errors++;
            $display("FAIL single%0d_data: got p=%h t=%0d c=%b want p=%h t=%0d c=%b",
                     n, out_product, out_tag, out_carry, tp[n], tt[n], tc[n]);
          end
        end
        if (k == 3) begin
          checks++;
          if (err_sticky !== te[n]) begin errors++; $display("FAIL single%0d_err: got %b want %b", n, err_sticky, te[n]); end
        end
        @(posedge clk);
        #0;
      end
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_sticky_persist;
    for (int k = 0; k < 4; k++) begin
      in_valid = (k == 0); in_row_a = 16'h0001; in_row_b = 16'h0001; in_tag = 4'd6; out_ready = 1'b1;
      #1;
      if (k == 2) begin
        checks++;
        if ({out_valid, out_product, out_carry} !== {1'b1, 16'h0002, 1'b0}) begin
          errors++; $display("FAIL clean_after_ovf: got v=%b p=%h c=%b want v=1 p=0002 c=0", out_valid, out_product, out_carry);
        end
      end
      tick();
    end
    checks++;
    if (err_sticky !== 1'b1) begin errors++; $display("FAIL sticky_hold: got %b want 1", err_sticky); end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] ra[3] = '{16'h0001, 16'h00FF, 16'hFF00};
    logic [15:0] rb[3] = '{16'h0000, 16'h0001, 16'h00FF};
    logic [15:0] ep[3] = '{16'h0001, 16'h0100, 16'hFFFF};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 3);
      in_row_a = ra[k % 3]; in_row_b = rb[k % 3]; in_tag = 4'(k % 3 + 1);
      #1;
      if (k < 3) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_k%0d: got %b want 1", k, in_ready); end
      end
      checks++;
      if (k >= 2 && k <= 4) begin
        if ({out_valid, out_product, out_tag} !== {1'b1, ep[k-2], 4'(k - 1)}) begin
          errors++;
          $display("FAIL b2b_out_k%0d: got v=%b p=%h t=%0d want v=1 p=%h t=%0d", k, out_valid, out_product, out_tag, ep[k-2], k - 1);
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_idle_k%0d: got out_valid=%b want 0", k, out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    item_t q[$];
    logic [15:0] held = '0;
    logic        seen = 1'b0;
    int          got = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_row_a = 16'($urandom_range(0, 16'h7FFF)); in_row_b = 16'($urandom_range(0, 16'h7FFF));
      in_tag = 4'(8 + k);
      #1;
      if (out_valid) begin
        if (seen) begin
          checks++;
          if (out_product !== held) begin errors++; $display("FAIL bp_stall_hold: got %h want %h", out_product, held); end
        end
        held = out_product; seen = 1'b1;
      end
      if (in_ready) q.push_back('{{1'b0, in_row_a} + {1'b0, in_row_b}, in_tag, 0});
      tick();
    end
    checks++;
    if (q.size() != 2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_accepts: got accepts=%0d in_ready=%b want accepts=2 in_ready=0", q.size(), in_ready);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_duplicate: got extra product %h want none", out_product);
        end else begin
          if ({out_product, out_tag} !== {q[0].s[15:0], q[0].t}) begin
            errors++; $display("FAIL bp_order: got p=%h t=%0d want p=%h t=%0d", out_product, out_tag, q[0].s[15:0], q[0].t);
          end
          void'(q.pop_front());
          got++;
        end
      end
      tick();
    end
    checks++;
    if (got != 2) begin errors++; $display("FAIL bp_drain: got %0d products want 2", got); end
  endtask

  task automatic test_random;
    item_t q[$];
    int    cyc = 0;
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_row_a = 16'($urandom); in_row_b = 16'($urandom); in_tag = 4'($urandom);
      #1;
      checks++;
      if (out_valid !== (q.size() > 0 && cyc >= q[0].acc + 1)) begin
        errors++; $display("FAIL rand_out_valid_c%0d: got %b want %b", cyc, out_valid, q.size() > 0 && cyc >= q[0].acc + 1);
      end
      checks++;
      if (in_ready !== !(q.size() == 2 && !out_ready)) begin
        errors++; $display("FAIL rand_in_ready_c%0d: got %b want %b", cyc, in_ready, !(q.size() == 2 && !out_ready));
      end
      if (out_valid && out_ready && q.size() > 0) begin
        checks++;
        if ({out_carry, out_product, out_tag} !== {q[0].s, q[0].t}) begin
          errors++;
          $display("FAIL rand_data_c%0d: got c=%b p=%h t=%0d want c=%b p=%h t=%0d",
                   cyc, out_carry, out_product, out_tag, q[0].s[16], q[0].s[15:0], q[0].t);
        end
        void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back('{{1'b0, in_row_a} + {1'b0, in_row_b}, in_tag, cyc + 1});
      @(posedge clk);
      cyc++;
      #0;
    end
    #1;
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b0; in_valid = 1'b1; in_row_a = 16'h1111; in_row_b = 16'h2222; in_tag = 4'd7;
    tick(); tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      errors++; $display("FAIL mid_full: got out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_product, out_tag, out_carry, err_sticky} !== '0) begin
      errors++;
      $display("FAIL mid_async_clear: got v=%b p=%h t=%h c=%b e=%b want all zero",
               out_valid, out_product, out_tag, out_carry, err_sticky);
    end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_k%0d: got out_valid=%b want 0", k, out_valid); end
    end
    in_valid = 1'b1; in_row_a = 16'h1234; in_row_b = 16'h0FCD; in_tag = 4'd9;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_product, out_tag, out_carry} !== {1'b1, 16'h2201, 4'd9, 1'b0}) begin
      errors++;
      $display("FAIL mid_first_new: got v=%b p=%h t=%0d c=%b want v=1 p=2201 t=9 c=0", out_valid, out_product, out_tag, out_carry);
    end
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_single_products();
    test_sticky_persist();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
